// File: rtl/wb_regfile.sv
// Writeback register file: 2^ASIZE x DSIZE entries, two combinational read ports with
// same-cycle write bypass, entry 0 hardwired to zero, and a registered commit trace.
module wb_regfile #(
    parameter int unsigned ASIZE = 5,
    parameter int unsigned DSIZE = 32,
    parameter int unsigned CSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic             commit_valid,
    output logic [ASIZE-1:0] commit_addr,
    output logic [DSIZE-1:0] commit_data,
    output logic [CSIZE-1:0] commit_cnt
);

    localparam int unsigned Depth = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [Depth];
    logic             wr_hit;
    logic             commit;

    // Writes to address 0 are not real writebacks; they neither store nor count.
    assign wr_hit = wen && (waddr != '0);
    assign commit = wr_hit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q        <= '{default: '0};
            commit_valid <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
            commit_cnt   <= '0;
        end else begin
            commit_valid <= commit;
            if (commit) begin
                mem_q[waddr] <= wdata;
                commit_addr  <= waddr;
                commit_data  <= wdata;
                commit_cnt   <= commit_cnt + CSIZE'(1);
            end
        end
    end

    // Bypass ignores rst so ID sees the in-flight value even during a reset cycle.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wr_hit && (waddr == raddr1)) ? wdata : mem_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = (wr_hit && (waddr == raddr2)) ? wdata : mem_q[raddr2];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

    localparam int unsigned ASIZE = 5;
    localparam int unsigned DSIZE = 32;
    localparam int unsigned CSIZE = 4;

    logic             clk;
    logic             rst;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE-1:0] raddr1;
    logic [ASIZE-1:0] raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic             commit_valid;
    logic [ASIZE-1:0] commit_addr;
    logic [DSIZE-1:0] commit_data;
    logic [CSIZE-1:0] commit_cnt;

    wb_regfile #(
        .ASIZE(ASIZE),
        .DSIZE(DSIZE),
        .CSIZE(CSIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .commit_valid(commit_valid),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_mem [32];
    logic        m_cv;
    logic [31:0] m_ca;
    logic [31:0] m_cd;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int ra);
        if (ra == 0) return 32'h0;
        if (wen && waddr != 0 && int'(waddr) == ra) return wdata;
        return m_mem[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_cv  = 1'b0;
        m_ca  = 32'h0;
        m_cd  = 32'h0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, check reads, take the edge, check commit outputs.
    task automatic step(input logic r, input logic w, input int wa, input logic [31:0] wd,
                        input int ra1, input int ra2);
        logic committed;
        rst    = r;
        wen    = w;
        waddr  = ASIZE'(wa);
        wdata  = wd;
        raddr1 = ASIZE'(ra1);
        raddr2 = ASIZE'(ra2);
        #1;
        chk("rdata1", rdata1, model_read(ra1));
        chk("rdata2", rdata2, model_read(ra2));
        @(posedge clk);
        committed = !r && w && (wa != 0);
        if (r) begin
            model_reset();
        end else begin
            m_cv = committed;
            if (committed) begin
                m_mem[wa] = wd;
                m_ca      = wa;
                m_cd      = wd;
                m_cnt     = (m_cnt + 1) % (1 << CSIZE);
            end
        end
        #1;
        chk("commit_valid", {31'h0, commit_valid}, {31'h0, m_cv});
        chk("commit_addr", {27'h0, commit_addr}, m_ca);
        chk("commit_data", commit_data, m_cd);
        chk("commit_cnt", {28'h0, commit_cnt}, 32'(m_cnt));
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset then read every address
        step(1, 0, 0, 0, 0, 0);
        for (int a = 1; a < 32; a++) step(0, 0, 0, 0, a, 32 - a);
        chk("rst_cnt", {28'h0, commit_cnt}, 32'h0);
        chk("rst_cv", {31'h0, commit_valid}, 32'h0);

        // Write then read
        step(0, 1, 5, 32'hDEADBEEF, 0, 0);
        chk("wr_cv", {31'h0, commit_valid}, 32'h1);
        chk("wr_ca", {27'h0, commit_addr}, 32'd5);
        chk("wr_cnt", {28'h0, commit_cnt}, 32'd1);
        step(0, 0, 0, 0, 5, 0);
        chk("wr_rd", rdata1, 32'hDEADBEEF);

        // Bypass on both ports at once
        step(0, 1, 7, 32'h11, 0, 0);
        rst = 0; wen = 1; waddr = 7; wdata = 32'h22; raddr1 = 7; raddr2 = 7;
        #1;
        chk("byp_rd1", rdata1, 32'h22);
        chk("byp_rd2", rdata2, 32'h22);
        step(0, 1, 7, 32'h22, 7, 7);
        step(0, 0, 0, 0, 7, 7);
        chk("byp_after", rdata1, 32'h22);

        // Register 0 is immutable and writes to it are not commits
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        chk("r0_cv", {31'h0, commit_valid}, 32'h0);
        chk("r0_cnt", {28'h0, commit_cnt}, 32'd3);
        step(0, 0, 0, 0, 0, 0);
        chk("r0_rd", rdata1, 32'h0);

        // Counter wrap after 17 commits from zero
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 3, 32'(i), 3, 0);
        chk("wrap_cnt", {28'h0, commit_cnt}, 32'd1);
        chk("wrap_cv", {31'h0, commit_valid}, 32'h1);

        // Reset priority over a coincident write
        step(1, 1, 9, 32'h55, 9, 0);
        chk("rstp_cnt", {28'h0, commit_cnt}, 32'h0);
        step(0, 0, 0, 0, 9, 3);
        chk("rstp_rd9", rdata1, 32'h0);
        chk("rstp_rd3", rdata2, 32'h0);

        // Write lands, then reset clears it
        step(0, 1, 12, 32'hA5A5A5A5, 0, 0);
        step(1, 0, 0, 0, 12, 0);
        step(0, 0, 0, 0, 12, 0);

        // Randomized traffic with focus on a small address set to provoke bypass hits
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic w;
            int   wa;
            int   ra1;
            int   ra2;
            r   = ($urandom_range(0, 39) == 0);
            w   = ($urandom_range(0, 2) != 0);
            wa  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            ra1 = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 31);
            ra2 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
            step(r, w, wa, $urandom, ra1, ra2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
